vsim_msg_buffer: RTL and testbench



---
 rtl/vsim_msg_pkg.sv | 12 +
 rtl/vsim_msg_if.sv | 16 +
 rtl/vsim_msg_store.sv | 40 ++++
 rtl/vsim_msg_buffer.sv | 59 +++++
 tb/tb_vsim_msg_buffer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vsim_msg_pkg.sv
// vsim_msg_pkg: shared state, entry type and default sizing for the message buffer
// No ports; imported by the buffer, its storage and its bus interface.
package vsim_msg_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_CNT_WIDTH = 16;
  typedef enum logic {STORE = 1'b0, CUT = 1'b1} state_e;
  typedef struct packed {
    logic last;
    logic [DEF_WIDTH-1:0] v;
  } entry_t;
endpackage

// File: rtl/vsim_msg_if.sv
// vsim_msg_if: enq/deq handshake bundle between host endpoint, buffer and user logic
interface vsim_msg_if #(
  parameter int width = vsim_msg_pkg::DEF_WIDTH
);
  logic enq__ENA, enq_last, enq__RDY;
  logic deq__ENA, deq_last, deq__RDY;
  logic [width-1:0] enq_v, deq_v;
  modport master (
    output enq__ENA, enq_v, enq_last, deq__RDY,
    input enq__RDY, deq__ENA, deq_v, deq_last
  );
  modport slave (
    input enq__ENA, enq_v, enq_last, deq__RDY,
    output enq__RDY, deq__ENA, deq_v, deq_last
  );
endinterface

// File: rtl/vsim_msg_store.sv
// vsim_msg_store: circular {last, v} storage with write/read pointers and occupancy
// clk, rst: clock and sync active-high reset; wr_i/wdata_i: push; rd_i: pop
// head_o: entry at read pointer; occ_o: words held; full_o/empty_o: occupancy flags
module vsim_msg_store import vsim_msg_pkg::*; #(
  parameter int width = DEF_WIDTH,
  parameter int depth = DEF_DEPTH,
  localparam int aw = $clog2(depth),
  localparam int ow = aw + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_i,
  input  logic           rd_i,
  input  logic [width:0] wdata_i,
  output logic [width:0] head_o,
  output logic [ow-1:0]  occ_o,
  output logic           full_o,
  output logic           empty_o
);
  logic [width:0] mem_q [depth];
  logic [aw-1:0] wp_q, rp_q;
  logic [ow-1:0] occ_q;
  always_ff @(posedge clk)
    if (wr_i) mem_q[wp_q] <= wdata_i;
  // depth is a power of two, so pointer wrap is plain overflow
  always_ff @(posedge clk)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      occ_q <= '0;
    end else begin
      if (wr_i) wp_q <= wp_q + 1'b1;
      if (rd_i) rp_q <= rp_q + 1'b1;
      occ_q <= occ_q + ow'(wr_i) - ow'(rd_i);
    end
  assign head_o = mem_q[rp_q];
  assign occ_o = occ_q;
  assign full_o = occ_q == ow'(depth);
  assign empty_o = occ_q == '0;
endmodule

// File: rtl/vsim_msg_buffer.sv
// vsim_msg_buffer: store-and-forward message buffer with cut-through fallback for oversize messages
module vsim_msg_buffer import vsim_msg_pkg::*; #(
  parameter int width = DEF_WIDTH,
  parameter int depth = DEF_DEPTH,
  parameter int cntWidth = DEF_CNT_WIDTH,
  localparam int cw = $clog2(depth) + 1
) (
  input  logic                CLK,
  input  logic                RST,
  vsim_msg_if.slave           bus,
  output logic [cw-1:0]       occupancy,
  output logic [cw-1:0]       msgCount,
  output logic                cutActive,
  output logic [cntWidth-1:0] oversizeCount
);
  state_e state_q, state_d;
  logic [cw-1:0] msg_q, msg_d;
  logic [cntWidth-1:0] ovf_q, ovf_d;
  logic [width:0] head;
  logic full, empty, wr, rd, eligible, enter_cut, rd_last;
  vsim_msg_store #(.width(width), .depth(depth)) u_store (
    .clk(CLK),
    .rst(RST),
    .wr_i(wr),
    .rd_i(rd),
    .wdata_i({bus.enq_last, bus.enq_v}),
    .head_o(head),
    .occ_o(occupancy),
    .full_o(full),
    .empty_o(empty)
  );
  assign bus.enq__RDY = !RST && !full;
  assign bus.deq__ENA = !RST && eligible && bus.deq__RDY;
  assign bus.deq_v = head[width-1:0];
  assign bus.deq_last = head[width];
  always_comb begin
    wr = bus.enq__ENA && bus.enq__RDY;
    rd = bus.deq__ENA;
    rd_last = rd && head[width];
    eligible = (state_q == CUT) ? !empty : msg_q != '0;
    enter_cut = state_q == STORE && full && msg_q == '0;
    msg_d = msg_q + cw'(wr && bus.enq_last) - cw'(rd_last);
    state_d = enter_cut ? CUT : rd_last ? STORE : state_q;
    ovf_d = (enter_cut && ovf_q != '1) ? ovf_q + 1'b1 : ovf_q;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state_q <= STORE;
      msg_q <= '0;
      ovf_q <= '0;
    end else begin
      state_q <= state_d;
      msg_q <= msg_d;
      ovf_q <= ovf_d;
    end
  assign msgCount = msg_q;
  assign cutActive = state_q == CUT;
  assign oversizeCount = ovf_q;
endmodule

// File: tb/tb_vsim_msg_buffer.sv
// tb_vsim_msg_buffer: directed self-checking bench for vsim_msg_buffer (depth 4, 2-bit oversize counter)
module tb_vsim_msg_buffer;
  localparam int W = 32;
  localparam int D = 4;
  localparam int CWID = 2;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [2:0] occupancy, msgCount;
  logic cutActive;
  logic [CWID-1:0] oversizeCount;
  int n_checks = 0;
  int n_fail = 0;
  vsim_msg_if #(.width(W)) bus();
  vsim_msg_buffer #(.width(W), .depth(D), .cntWidth(CWID)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus),
    .occupancy(occupancy),
    .msgCount(msgCount),
    .cutActive(cutActive),
    .oversizeCount(oversizeCount)
  );
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset;
    RST = 1'b1;
    bus.enq__ENA = 1'b1;
    bus.enq_v = 32'hDEAD;
    bus.enq_last = 1'b1;
    bus.deq__RDY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++; if (bus.enq__RDY !== 1'b0) begin n_fail++; $display("FAIL reset_enq_rdy cyc %0d got %b exp 0", i, bus.enq__RDY); end
      n_checks++; if (bus.deq__ENA !== 1'b0) begin n_fail++; $display("FAIL reset_deq_ena cyc %0d got %b exp 0", i, bus.deq__ENA); end
    end
    RST = 1'b0;
    bus.enq__ENA = 1'b0;
    #1;
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    n_checks++; if (msgCount !== 3'd0) begin n_fail++; $display("FAIL reset_msg got %0d exp 0", msgCount); end
    n_checks++; if (cutActive !== 1'b0) begin n_fail++; $display("FAIL reset_cut got %b exp 0", cutActive); end
    n_checks++; if (oversizeCount !== 2'd0) begin n_fail++; $display("FAIL reset_ovf got %0d exp 0", oversizeCount); end
    n_checks++; if (bus.enq__RDY !== 1'b1) begin n_fail++; $display("FAIL reset_enq_rdy_after got %b exp 1", bus.enq__RDY); end
    n_checks++; if (bus.deq__ENA !== 1'b0) begin n_fail++; $display("FAIL reset_deq_after got %b exp 0", bus.deq__ENA); end
  endtask
  task automatic test_store_forward;
    logic [31:0] w [3] = '{32'h11, 32'h22, 32'h33};
    bus.deq__RDY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.enq__ENA = 1'b1;
      bus.enq_v = w[i];
      bus.enq_last = (i == 2);
      #1;
      n_checks++; if (bus.deq__ENA !== 1'b0) begin n_fail++; $display("FAIL sf_hold word %0d got %b exp 0", i, bus.deq__ENA); end
      tick;
    end
    bus.enq__ENA = 1'b0;
    bus.enq_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.deq__ENA !== 1'b1) begin n_fail++; $display("FAIL sf_ena word %0d got %b exp 1", i, bus.deq__ENA); end
      n_checks++; if (bus.deq_v !== w[i]) begin n_fail++; $display("FAIL sf_data word %0d got %h exp %h", i, bus.deq_v, w[i]); end
      n_checks++; if (bus.deq_last !== (i == 2)) begin n_fail++; $display("FAIL sf_last word %0d got %b exp %b", i, bus.deq_last, i == 2); end
      n_checks++; if (msgCount !== 3'd1) begin n_fail++; $display("FAIL sf_msg word %0d got %0d exp 1", i, msgCount); end
      tick;
    end
    #1;
    n_checks++; if (msgCount !== 3'd0) begin n_fail++; $display("FAIL sf_msg_end got %0d exp 0", msgCount); end
    n_checks++; if (bus.deq__ENA !== 1'b0) begin n_fail++; $display("FAIL sf_ena_end got %b exp 0", bus.deq__ENA); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL sf_occ_end got %0d exp 0", occupancy); end
  endtask
  task automatic test_backpressure;
    logic [31:0] w [4] = '{32'h41, 32'h42, 32'h51, 32'h52};
    int exp_msg;
    logic rdy;
    bus.deq__RDY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.enq__ENA = 1'b1;
      bus.enq_v = w[i];
      bus.enq_last = (i % 2 == 1);
      tick;
    end
    bus.enq__ENA = 1'b0;
    #1;
    n_checks++; if (msgCount !== 3'd2) begin n_fail++; $display("FAIL bp_msg_start got %0d exp 2", msgCount); end
    n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_occ_full got %0d exp 4", occupancy); end
    n_checks++; if (bus.enq__RDY !== 1'b0) begin n_fail++; $display("FAIL bp_enq_rdy_full got %b exp 0", bus.enq__RDY); end
    n_checks++; if (cutActive !== 1'b0) begin n_fail++; $display("FAIL bp_no_cut got %b exp 0", cutActive); end
    for (int c = 0; c < 8; c++) begin
      rdy = (c % 2 == 0);
      bus.deq__RDY = rdy;
      exp_msg = 2 - int'(c >= 3) - int'(c >= 7);
      #1;
      n_checks++; if (bus.deq__ENA !== rdy) begin n_fail++; $display("FAIL bp_ena cyc %0d got %b exp %b", c, bus.deq__ENA, rdy); end
      if (rdy) begin
        n_checks++; if (bus.deq_v !== w[c/2]) begin n_fail++; $display("FAIL bp_data cyc %0d got %h exp %h", c, bus.deq_v, w[c/2]); end
        n_checks++; if (bus.deq_last !== ((c/2) % 2 == 1)) begin n_fail++; $display("FAIL bp_last cyc %0d got %b", c, bus.deq_last); end
      end
      n_checks++; if (int'(msgCount) !== exp_msg) begin n_fail++; $display("FAIL bp_msg cyc %0d got %0d exp %0d", c, msgCount, exp_msg); end
      tick;
    end
    bus.deq__RDY = 1'b1;
  endtask
  task automatic run_oversize(input int exp_cnt, input logic [31:0] base);
    int w = 0;
    int r = 0;
    int first = -1;
    bus.deq__RDY = 1'b1;
    for (int c = 0; c < 30 && r < 6; c++) begin
      bus.enq__ENA = (w < 6);
      bus.enq_v = base + 32'(w);
      bus.enq_last = (w == 5);
      #1;
      if (c == 4) begin
        n_checks++; if (cutActive !== 1'b0) begin n_fail++; $display("FAIL os_cut_pre base %h got %b exp 0", base, cutActive); end
        n_checks++; if (bus.enq__RDY !== 1'b0) begin n_fail++; $display("FAIL os_full_rdy base %h got %b exp 0", base, bus.enq__RDY); end
        n_checks++; if (bus.deq__ENA !== 1'b0) begin n_fail++; $display("FAIL os_stall base %h got %b exp 0", base, bus.deq__ENA); end
      end
      if (c == 5) begin
        n_checks++; if (cutActive !== 1'b1) begin n_fail++; $display("FAIL os_cut base %h got %b exp 1", base, cutActive); end
        n_checks++; if (int'(oversizeCount) !== exp_cnt) begin n_fail++; $display("FAIL os_count base %h got %0d exp %0d", base, oversizeCount, exp_cnt); end
      end
      if (bus.deq__ENA) begin
        if (first < 0) first = c;
        n_checks++; if (bus.deq_v !== base + 32'(r)) begin n_fail++; $display("FAIL os_data base %h idx %0d got %h exp %h", base, r, bus.deq_v, base + 32'(r)); end
        n_checks++; if (bus.deq_last !== (r == 5)) begin n_fail++; $display("FAIL os_last base %h idx %0d got %b", base, r, bus.deq_last); end
        r++;
      end
      if (bus.enq__ENA && bus.enq__RDY) w++;
      tick;
    end
    bus.enq__ENA = 1'b0;
    bus.enq_last = 1'b0;
    #1;
    n_checks++; if (r !== 6) begin n_fail++; $display("FAIL os_timeout base %h got %0d words exp 6", base, r); end
    n_checks++; if (first !== 5) begin n_fail++; $display("FAIL os_first_read base %h got cyc %0d exp 5", base, first); end
    n_checks++; if (cutActive !== 1'b0) begin n_fail++; $display("FAIL os_cut_drop base %h got %b exp 0", base, cutActive); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL os_occ_end base %h got %0d exp 0", base, occupancy); end
    n_checks++; if (msgCount !== 3'd0) begin n_fail++; $display("FAIL os_msg_end base %h got %0d exp 0", base, msgCount); end
    n_checks++; if (int'(oversizeCount) !== exp_cnt) begin n_fail++; $display("FAIL os_count_end base %h got %0d exp %0d", base, oversizeCount, exp_cnt); end
  endtask
  task automatic test_oversize;
    run_oversize(1, 32'hA0);
  endtask
  task automatic test_saturate;
    run_oversize(2, 32'hB0);
    run_oversize(3, 32'hC0);
    run_oversize(3, 32'hD0);
  endtask
  task automatic test_full_simul;
    logic [31:0] exp_v;
    bus.deq__RDY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.enq__ENA = 1'b1;
      bus.enq_v = 32'h61 + 32'(i);
      bus.enq_last = 1'b1;
      tick;
    end
    bus.enq_v = 32'h65;
    #1;
    n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL fs_occ_full got %0d exp 4", occupancy); end
    n_checks++; if (msgCount !== 3'd4) begin n_fail++; $display("FAIL fs_msg_full got %0d exp 4", msgCount); end
    n_checks++; if (bus.enq__RDY !== 1'b0) begin n_fail++; $display("FAIL fs_rdy_full got %b exp 0", bus.enq__RDY); end
    bus.deq__RDY = 1'b1;
    for (int d = 0; d < 4; d++) begin
      bus.enq_v = (d == 0) ? 32'h65 : 32'h64 + 32'(d);
      #1;
      n_checks++; if (bus.enq__RDY !== (d != 0)) begin n_fail++; $display("FAIL fs_rdy cyc %0d got %b exp %b", d, bus.enq__RDY, d != 0); end
      n_checks++; if (int'(occupancy) !== ((d == 0) ? 4 : 3)) begin n_fail++; $display("FAIL fs_occ cyc %0d got %0d", d, occupancy); end
      n_checks++; if (bus.deq__ENA !== 1'b1) begin n_fail++; $display("FAIL fs_ena cyc %0d got %b exp 1", d, bus.deq__ENA); end
      n_checks++; if (bus.deq_v !== 32'h61 + 32'(d)) begin n_fail++; $display("FAIL fs_data cyc %0d got %h exp %h", d, bus.deq_v, 32'h61 + 32'(d)); end
      tick;
    end
    bus.enq__ENA = 1'b0;
    for (int d = 0; d < 3; d++) begin
      exp_v = 32'h65 + 32'(d);
      #1;
      n_checks++; if (bus.deq_v !== exp_v) begin n_fail++; $display("FAIL fs_drain cyc %0d got %h exp %h", d, bus.deq_v, exp_v); end
      n_checks++; if (int'(occupancy) !== 3 - d) begin n_fail++; $display("FAIL fs_drain_occ cyc %0d got %0d exp %0d", d, occupancy, 3 - d); end
      tick;
    end
    #1;
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL fs_occ_end got %0d exp 0", occupancy); end
    n_checks++; if (msgCount !== 3'd0) begin n_fail++; $display("FAIL fs_msg_end got %0d exp 0", msgCount); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] w [3] = '{32'h71, 32'h72, 32'h73};
    bus.deq__RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.enq__ENA = 1'b1;
      bus.enq_v = w[i];
      bus.enq_last = (i < 2);
      tick;
    end
    bus.enq__ENA = 1'b0;
    #1;
    n_checks++; if (msgCount !== 3'd2) begin n_fail++; $display("FAIL rm_msg_pre got %0d exp 2", msgCount); end
    n_checks++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL rm_occ_pre got %0d exp 3", occupancy); end
    RST = 1'b1;
    tick;
    n_checks++; if (bus.enq__RDY !== 1'b0) begin n_fail++; $display("FAIL rm_rdy_in_reset got %b exp 0", bus.enq__RDY); end
    RST = 1'b0;
    bus.deq__RDY = 1'b1;
    #1;
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rm_occ got %0d exp 0", occupancy); end
    n_checks++; if (msgCount !== 3'd0) begin n_fail++; $display("FAIL rm_msg got %0d exp 0", msgCount); end
    n_checks++; if (oversizeCount !== 2'd0) begin n_fail++; $display("FAIL rm_ovf got %0d exp 0", oversizeCount); end
    n_checks++; if (cutActive !== 1'b0) begin n_fail++; $display("FAIL rm_cut got %b exp 0", cutActive); end
    n_checks++; if (bus.deq__ENA !== 1'b0) begin n_fail++; $display("FAIL rm_deq got %b exp 0", bus.deq__ENA); end
    bus.deq__RDY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.enq__ENA = 1'b1;
      bus.enq_v = 32'h81 + 32'(i);
      bus.enq_last = (i == 1);
      tick;
    end
    bus.enq__ENA = 1'b0;
    bus.deq__RDY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (bus.deq__ENA !== 1'b1) begin n_fail++; $display("FAIL rm_next_ena idx %0d got %b exp 1", i, bus.deq__ENA); end
      n_checks++; if (bus.deq_v !== 32'h81 + 32'(i)) begin n_fail++; $display("FAIL rm_next_data idx %0d got %h exp %h", i, bus.deq_v, 32'h81 + 32'(i)); end
      n_checks++; if (bus.deq_last !== (i == 1)) begin n_fail++; $display("FAIL rm_next_last idx %0d got %b", i, bus.deq_last); end
      tick;
    end
    #1;
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rm_occ_end got %0d exp 0", occupancy); end
  endtask
  initial begin
    bus.enq__ENA = 1'b0;
    bus.enq_v = '0;
    bus.enq_last = 1'b0;
    bus.deq__RDY = 1'b0;
    test_reset;
    test_store_forward;
    test_backpressure;
    test_oversize;
    test_saturate;
    test_full_simul;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
